// File: rtl/eth_tx_arb_pkg.sv
// rtl/eth_tx_arb_pkg.sv - shared types and width helpers for the Ethernet TX arbiter
//
// Purpose : arbiter state encoding plus width helpers. Each helper is
//           evaluated from the instantiating module's own parameters, so one
//           package serves every parameterisation:
//             idx_w(N_REQ)      -> IDX_W, requester index width (min 1)
//             cnt_w(MAX_FRAME)  -> CNT_W = $clog2(MAX_FRAME+1)
//             gap_w(GAP_CYCLES) -> GAP_W = $clog2(GAP_CYCLES+1)
// Ports   : none (package)

package eth_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int max_frame);
    return $clog2(max_frame + 1);
  endfunction

  function automatic int gap_w(input int gap_cycles);
    return $clog2(gap_cycles + 1);
  endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// rtl/arb_rr_picker.sv - combinational round-robin / fixed-priority winner picker
//
// Purpose : picks one requester from i_req. The default build searches
//           upward from i_ptr with wrap-around. With ETH_TX_ARB_FIXED_PRIO_EN
//           defined, the lowest set index always wins and i_ptr is ignored.
// Ports   : i_req    [N_REQ-1:0]  request vector
//           i_ptr    [IDX_W-1:0]  index with highest priority (round-robin only)
//           o_onehot [N_REQ-1:0]  one-hot winner, 0 when i_req == 0
//           o_idx    [IDX_W-1:0]  winner index, 0 when i_req == 0

module arb_rr_picker
  import eth_tx_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0] o_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_k;

`ifdef ETH_TX_ARB_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;
`else
  logic [IDX_W:0] w_sum;
`endif

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_k      = '0;
`ifndef ETH_TX_ARB_FIXED_PRIO_EN
    w_sum    = '0;
`endif
    for (int i = 0; i < N_REQ; i++) begin
`ifdef ETH_TX_ARB_FIXED_PRIO_EN
      w_k = IDX_W'(i);
`else
      // candidate = (ptr + i) mod N_REQ; one extra bit keeps the sum exact
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(i);
      if (w_sum >= (IDX_W+1)'(N_REQ)) w_sum = w_sum - (IDX_W+1)'(N_REQ);
      w_k = w_sum[IDX_W-1:0];
`endif
      if (!w_found && i_req[w_k]) begin
        w_found       = 1'b1;
        o_onehot[w_k] = 1'b1;
        o_idx         = w_k;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - whole-frame arbiter sharing the Ethernet TX byte port
//
// Purpose : grants the MAC write port to one requester for a whole frame,
//           forwards its bytes with zero added latency, truncates frames at
//           MAX_FRAME bytes and enforces GAP_CYCLES idle cycles after each.
//           Optional macro ETH_TX_ARB_FIXED_PRIO_EN: fixed priority (lowest
//           index wins) instead of round-robin.
// Ports   : i_clk, i_rst            clock, synchronous active-high reset
//           i_req/i_valid/i_last    per-requester request, byte valid, last byte
//           i_data [8*N_REQ-1:0]    requester k drives [8k+7:8k]
//           o_gnt                   one-hot grant held for the frame
//           o_ready                 byte of requester k accepted when o_ready[k] & i_valid[k]
//           o_wdata/o_wvalid/i_wready  MAC byte interface
//           o_busy                  state != IDLE
//           o_trunc                 sticky truncation flag

module eth_tx_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int MAX_FRAME  = 64,
  parameter int GAP_CYCLES = 12
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [8*N_REQ-1:0] i_data,
  input  logic [N_REQ-1:0]   i_valid,
  input  logic [N_REQ-1:0]   i_last,
  output logic [N_REQ-1:0]   o_gnt,
  output logic [N_REQ-1:0]   o_ready,
  output logic [7:0]         o_wdata,
  output logic               o_wvalid,
  input  logic               i_wready,
  output logic               o_busy,
  output logic               o_trunc
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int CNT_W = cnt_w(MAX_FRAME);
  localparam int GAP_W = gap_w(GAP_CYCLES);

  arb_state_t       r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt;
  logic [IDX_W-1:0] r_gidx;
  logic [CNT_W-1:0] r_cnt;
  logic [GAP_W-1:0] r_gap;
  logic             r_trunc;

  logic [N_REQ-1:0] w_win_oh;
  logic [IDX_W-1:0] w_win_idx;
  logic [IDX_W-1:0] w_ptr;
  logic [7:0]       w_sel_data;
  logic             w_sel_valid, w_sel_last;
  logic             w_xfer, w_frame_end, w_cut;

`ifdef ETH_TX_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IDX_W-1:0] r_ptr;
  assign w_ptr = r_ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (r_state == IDLE && |i_req) begin
      r_ptr <= (w_win_idx == IDX_W'(N_REQ-1)) ? '0 : w_win_idx + IDX_W'(1);
    end
  end
`endif

  arb_rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
    .i_req    (i_req),
    .i_ptr    (w_ptr),
    .o_onehot (w_win_oh),
    .o_idx    (w_win_idx)
  );

  // granted requester's byte lane
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_gidx == IDX_W'(k)) begin
        w_sel_data  = i_data[8*k +: 8];
        w_sel_valid = i_valid[k];
        w_sel_last  = i_last[k];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_wdata     = '0;
    o_wvalid    = 1'b0;
    o_ready     = '0;
    w_xfer      = 1'b0;
    w_frame_end = 1'b0;
    w_cut       = 1'b0;
    case (r_state)
      IDLE: begin
        if (|i_req) w_state_nxt = SEND;
      end
      SEND: begin
        o_wdata  = w_sel_data;
        o_wvalid = w_sel_valid;
        o_ready  = r_gnt & {N_REQ{i_wready}};
        w_xfer   = w_sel_valid & i_wready;
        if (w_xfer) begin
          if (w_sel_last) begin
            w_frame_end = 1'b1;
          end else if (r_cnt == CNT_W'(MAX_FRAME-1)) begin
            w_frame_end = 1'b1;
            w_cut       = 1'b1;
          end
        end
        if (w_frame_end) w_state_nxt = GAP;
      end
      GAP: begin
        if (r_gap == '0) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gnt   <= '0;
      r_gidx  <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_trunc <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|i_req) begin
            r_gnt  <= w_win_oh;
            r_gidx <= w_win_idx;
            r_cnt  <= '0;
          end
        end
        SEND: begin
          if (w_xfer) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_frame_end) begin
              r_gnt <= '0;
              r_gap <= GAP_W'(GAP_CYCLES-1);
            end
            if (w_cut) r_trunc <= 1'b1;
          end
        end
        GAP: begin
          if (r_gap != '0) r_gap <= r_gap - GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_gnt   = r_gnt;
  assign o_busy  = (r_state != IDLE);
  assign o_trunc = r_trunc;

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Shares the single Ethernet TX byte port (o_wdata/o_wvalid/i_wready) between N frame sources, e.g. the ping responder and frame_assembly.
- Grants whole frames only. No interleaving of bytes from different sources.
- Inserts a programmable idle gap between frames.
- Sits between the protocol FSMs and the eth MAC write interface. Replaces the ad-hoc link-based output mux.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- MAX_FRAME, 64, byte-count watchdog; a frame is forcibly terminated at this length.
- GAP_CYCLES, 12, idle cycles enforced after every frame (>=1).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_req  in  N_REQ  requester k has a frame pending
- i_data  in  8*N_REQ  packed bytes; requester k drives [8k+7:8k]
- i_valid  in  N_REQ  byte on i_data[k] valid
- i_last  in  N_REQ  current byte is the final byte of the frame
- o_gnt  out  N_REQ  one-hot grant, held for the whole frame
- o_ready  out  N_REQ  byte of requester k accepted this cycle when o_ready[k] & i_valid[k]
- o_wdata  out  8  byte to MAC
- o_wvalid  out  1  byte valid to MAC
- i_wready  in  1  MAC can accept a byte
- o_busy  out  1  state != IDLE
- o_trunc  out  1  sticky: a frame hit MAX_FRAME without i_last; cleared only by reset

Behaviour:
- Reset (synchronous, i_rst=1 at posedge): state=IDLE, o_gnt=0, o_busy=0, o_trunc=0, byte counter=0, gap counter=0, RR pointer=0 (requester 0 has highest priority next).
- Reset asserted mid-frame aborts immediately. Next cycle o_wvalid=0; no completion of the partial frame.
- States: IDLE, SEND, GAP.
- IDLE:
  - If i_req!=0, pick the winner round-robin, searching from index ptr upward with wrap.
  - Register o_gnt=onehot(winner) and ptr=winner+1 mod N_REQ; go to SEND.
  - Grant is visible the cycle after the request (1-cycle arbitration latency).
  - i_req=0 means stay in IDLE.
- SEND (combinational datapath, zero added latency):
  - o_wdata=i_data[g], o_wvalid=i_valid[g], o_ready[g]=i_wready; o_ready of all other bits=0.
  - A transfer occurs when o_wvalid & i_wready.
  - Each transfer increments the byte counter (width clog2(MAX_FRAME+1)).
  - Transfer with i_last[g]=1 ends the frame: go to GAP, gap counter=GAP_CYCLES-1, o_gnt cleared.
  - Transfer where counter==MAX_FRAME-1 and i_last[g]=0 also ends the frame: o_trunc<=1, go to GAP.
    - The requester is not told; it must observe o_gnt drop.
    - Its further bytes see o_ready=0.
  - i_req[g] deasserting mid-frame is ignored; the grant holds until a last byte or truncation.
  - i_valid[g]=0 or i_wready=0 means stall; counters hold with no timeout.
- GAP:
  - o_wvalid=0, o_wdata=8'h00, o_ready=0.
  - Decrement the gap counter; at 0 go to IDLE.
  - Minimum frame-end to next-grant spacing is GAP_CYCLES+1 cycles.
- Outside SEND: o_wdata=0, o_wvalid=0, o_ready=0.
- Requests arriving during SEND/GAP are not lost. i_req is level-sampled in IDLE only.
- Simultaneous requests from all sources: serviced in strict rotation, each one frame per turn.
- Single requester continuously requesting: back-to-back frames separated by the gap.

Optional Feature:
- Macro: ETH_TX_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; lowest index with i_req set always wins; RR pointer logic removed.
- Undefined (default): round-robin as above.

Decomposition:
- Package eth_tx_arb_pkg:
  - state enum (IDLE, SEND, GAP);
  - localparam widths CNT_W=$clog2(MAX_FRAME+1), GAP_W=$clog2(GAP_CYCLES+1);
  - IDX_W=$clog2(N_REQ) helper.
- One sub-module arb_rr_picker: combinational; inputs req vector and ptr; outputs one-hot winner and index.
- The macro selects the fixed-priority path inside arb_rr_picker.

Test Plan:
- Reset mid-frame:
  - Stimulus: reset, then requester 0 sends 3 bytes 0xA1,0xA2,0xA3(last) with i_wready=1.
  - Required: o_gnt=01 one cycle after i_req; o_wdata sequence A1,A2,A3; o_gnt=00 after A3; o_wvalid low exactly GAP_CYCLES cycles after, then IDLE.
  - Then assert i_rst mid-frame: o_wvalid=0 next cycle; o_busy=0.
- Both requesters at once, repeated:
  - Stimulus: i_req=11 held, each requester sending 2-byte frames.
  - Required: grant order 0,1,0,1.
  - With ETH_TX_ARB_FIXED_PRIO_EN: 0,0,0.
- Backpressure:
  - Stimulus: toggle i_wready 1,0,0,1,1 during a 4-byte frame.
  - Required: no byte dropped or duplicated; o_ready tracks i_wready; counter holds during stalls.
- Truncation:
  - Stimulus: MAX_FRAME=8, requester 1 sends 10 bytes with no i_last.
  - Required: exactly 8 bytes forwarded; o_trunc=1 and sticky; o_ready[1]=0 afterwards.
- Mid-frame request drop:
  - Stimulus: i_req[0] dropped after byte 1 of a 4-byte frame.
  - Required: grant retained; all 4 bytes delivered; ungranted requester's o_ready stays 0 throughout.
